// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish evaluation controller driving an external LIFO stack.
// Optional build macro RPN_FLAG_CHECK_EN: cross-checks the stack's empty/full flags against the internal depth.
module rpn_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         tok_valid,
    output logic                         tok_ready,
    input  logic                         tok_is_op,
    input  logic [WIDTH-1:0]             tok_data,
    output logic                         stk_enable,
    output logic                         stk_push_pop,
    output logic [WIDTH-1:0]             stk_data_in,
    input  logic [WIDTH-1:0]             stk_data_out,
    input  logic                         stk_empty,
    input  logic                         stk_full,
    output logic                         res_valid,
    output logic [WIDTH-1:0]             res_data,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err,
    output logic [2:0]                   err_code
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_RES = 3'd7;

    localparam logic [2:0] E_OVERFLOW  = 3'd1;
    localparam logic [2:0] E_UNDERFLOW = 3'd2;
    localparam logic [2:0] E_FLAGS     = 3'd3;
    localparam logic [2:0] E_ILLEGAL   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_LATCH_A, S_PUSH_R, S_OUT, S_ERR
    } state_t;

    state_t           state, next_state;
    logic [2:0]       next_code;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;
    logic             flag_mismatch;

    assign accept = tok_valid & tok_ready;

`ifdef RPN_FLAG_CHECK_EN
    assign flag_mismatch = (stk_empty != (depth == '0)) || (stk_full != (depth == DEPTH_MAX));
`else
    logic unused_flags;
    assign unused_flags  = stk_empty ^ stk_full;
    assign flag_mismatch = 1'b0;
`endif

    // a is the deeper element (second pop), b the former top of stack.
    function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return '0;
        endcase
    endfunction

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        next_code  = 3'd0;
        case (state)
            S_IDLE: begin
                if (flag_mismatch) begin
                    next_state = S_ERR;
                    next_code  = E_FLAGS;
                end else if (accept) begin
                    if (!tok_is_op) begin
                        if (depth == DEPTH_MAX) begin
                            next_state = S_ERR;
                            next_code  = E_OVERFLOW;
                        end else begin
                            next_state = S_PUSH;
                        end
                    end else begin
                        case (tok_data[2:0])
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                if (depth < DW'(2)) begin
                                    next_state = S_ERR;
                                    next_code  = E_UNDERFLOW;
                                end else begin
                                    next_state = S_POP_B;
                                end
                            end
                            OP_RES: begin
                                if (depth == '0) begin
                                    next_state = S_ERR;
                                    next_code  = E_UNDERFLOW;
                                end else begin
                                    next_state = S_POP_B;
                                end
                            end
                            default: begin
                                next_state = S_ERR;
                                next_code  = E_ILLEGAL;
                            end
                        endcase
                    end
                end
            end
            S_PUSH:    next_state = S_IDLE;
            S_POP_B:   next_state = (op_q == OP_RES) ? S_OUT : S_POP_A;
            S_POP_A:   next_state = S_LATCH_A;
            S_LATCH_A: next_state = S_PUSH_R;
            S_PUSH_R:  next_state = S_IDLE;
            S_OUT:     next_state = S_IDLE;
            S_ERR:     next_state = S_ERR;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so each strobe lines up with its state.
    // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tok_ready    <= 1'b0;
            stk_enable   <= 1'b0;
            stk_push_pop <= 1'b0;
            stk_data_in  <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            depth        <= '0;
            err          <= 1'b0;
            err_code     <= 3'd0;
            op_q         <= 3'd0;
            b_q          <= '0;
        end else begin
            state        <= next_state;
            tok_ready    <= (next_state == S_IDLE);
            stk_enable   <= (next_state == S_PUSH) || (next_state == S_POP_B) ||
                            (next_state == S_POP_A) || (next_state == S_PUSH_R);
            stk_push_pop <= (next_state == S_PUSH) || (next_state == S_PUSH_R);
            res_valid    <= (state == S_OUT);

            if (state == S_IDLE && accept) begin
                op_q <= tok_data[2:0];
                if (!tok_is_op) begin
                    stk_data_in <= tok_data;
                end
            end

            // Popped data appears one cycle after its strobe.
            if (state == S_POP_A) begin
                b_q <= stk_data_out;
            end
            if (state == S_LATCH_A) begin
                stk_data_in <= alu(op_q, stk_data_out, b_q);
            end
            if (state == S_OUT) begin
                res_data <= stk_data_out;
            end

            case (state)
                S_PUSH:          depth <= depth + DW'(1);
                S_PUSH_R, S_OUT: depth <= depth - DW'(1);
                default:         depth <= depth;
            endcase

            if (next_state == S_ERR && state != S_ERR) begin
                err      <= 1'b1;
                err_code <= next_code;
            end
        end
    end

endmodule
